audio_mixer: RTL and testbench

AUDIO_MIXER -- requirements
Module: audio_mixer

---
 rtl/audio_mixer_pkg.sv | 12 +
 rtl/audio_mixer_sat.sv | 16 +
 rtl/audio_mixer.sv | 122 ++++++++++++
 tb/tb_audio_mixer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_mixer_pkg.sv
// audio_mixer_pkg: shared FSM state type and sizing helpers for the audio mixer.
// Contents: state_t (IDLE/MAC/SAT), unity_gain() gain code for 1.0,
// acc_width() accumulator width that cannot overflow over all channels.
package audio_mixer_pkg;
   typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;
   function automatic int unity_gain(input int gain_width);
      return 1 << (gain_width - 1);
   endfunction
   function automatic int acc_width(input int in_width, input int gain_width, input int num_channels);
      return in_width + gain_width + $clog2(num_channels) + 1;
   endfunction
endpackage

// File: rtl/audio_mixer_sat.sv
// audio_mixer_sat: drops the gain fraction bits from an accumulator and clamps to the output range.
// Ports: acc (accumulated sum of sample*gain), sat (shifted, clamped result).
module audio_mixer_sat #(
   parameter int ACC_W      = 27,
   parameter int GAIN_WIDTH = 8,
   parameter int OUT_WIDTH  = 16
) (
   input  logic [ACC_W-1:0]     acc,
   output logic [OUT_WIDTH-1:0] sat
);
   localparam int EW = ACC_W + OUT_WIDTH;
   // Zero-extended so the slices below stay legal whatever ACC_W is relative to OUT_WIDTH.
   logic [EW-1:0] sh;
   assign sh  = {{OUT_WIDTH{1'b0}}, acc} >> (GAIN_WIDTH - 1);
   assign sat = |sh[EW-1:OUT_WIDTH] ? '1 : sh[OUT_WIDTH-1:0];
endmodule

// File: rtl/audio_mixer.sv
// audio_mixer: stereo mixer, one shared multiplier, 2*NUM_CHANNELS MAC cycles per sample.
// Ports: clk_logic clock; device_reset_n async active-low reset;
//   sample_strobe_i mix request; samples_i/gain_l_i/gain_r_i packed per channel;
//   overrun_clr_i clears overrun_o; audio_l_o/audio_r_o last mixed sample;
//   sample_valid_o one-cycle pulse on new output; busy_o not idle; overrun_o sticky drop flag.
// Optional AUDIO_MIXER_PEAK_EN: adds peak_clr_i, peak_l_o, peak_r_o (max output since clear).
module audio_mixer
   import audio_mixer_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int IN_WIDTH     = 16,
   parameter int GAIN_WIDTH   = 8,
   parameter int OUT_WIDTH    = 16
) (
   input  logic                             clk_logic,
   input  logic                             device_reset_n,
   input  logic                             sample_strobe_i,
   input  logic [NUM_CHANNELS*IN_WIDTH-1:0] samples_i,
   input  logic [NUM_CHANNELS*GAIN_WIDTH-1:0] gain_l_i,
   input  logic [NUM_CHANNELS*GAIN_WIDTH-1:0] gain_r_i,
   input  logic                             overrun_clr_i,
   output logic [OUT_WIDTH-1:0]             audio_l_o,
   output logic [OUT_WIDTH-1:0]             audio_r_o,
   output logic                             sample_valid_o,
   output logic                             busy_o,
   output logic                             overrun_o
`ifdef AUDIO_MIXER_PEAK_EN
   ,
   input  logic                             peak_clr_i,
   output logic [OUT_WIDTH-1:0]             peak_l_o,
   output logic [OUT_WIDTH-1:0]             peak_r_o
`endif
);
   localparam int ACC_W = acc_width(IN_WIDTH, GAIN_WIDTH, NUM_CHANNELS);
   localparam int IDX_W = $clog2(2 * NUM_CHANNELS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(2 * NUM_CHANNELS - 1);
   state_t state, state_nx;
   logic [IDX_W-1:0] idx, ch;
   logic [NUM_CHANNELS*IN_WIDTH-1:0] snap_s;
   logic [NUM_CHANNELS*GAIN_WIDTH-1:0] snap_gl, snap_gr;
   logic [ACC_W-1:0] acc_l, acc_r;
   logic [IN_WIDTH-1:0] smp;
   logic [GAIN_WIDTH-1:0] gain;
   logic [IN_WIDTH+GAIN_WIDTH-1:0] prod;
   logic [OUT_WIDTH-1:0] sat_l, sat_r;
   logic accept, drop;
   // Product index: bit 0 selects side (0 = left, 1 = right), upper bits select channel.
   assign ch     = idx >> 1;
   assign smp    = snap_s[ch*IN_WIDTH +: IN_WIDTH];
   assign gain   = idx[0] ? snap_gr[ch*GAIN_WIDTH +: GAIN_WIDTH] : snap_gl[ch*GAIN_WIDTH +: GAIN_WIDTH];
   assign prod   = smp * gain;
   assign accept = sample_strobe_i && state == IDLE;
   assign drop   = sample_strobe_i && state != IDLE;
   assign busy_o = state != IDLE;
   always_comb begin
      state_nx = IDLE;
      state_nx = (state == IDLE) ? (sample_strobe_i ? MAC : IDLE) :
                 (state == MAC)  ? (idx == LAST ? SAT : MAC) : IDLE;
   end
   always_ff @(posedge clk_logic or negedge device_reset_n) begin
      if (!device_reset_n) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk_logic or negedge device_reset_n) begin
      if (!device_reset_n) begin
         idx            <= '0;
         acc_l          <= '0;
         acc_r          <= '0;
         snap_s         <= '0;
         snap_gl        <= '0;
         snap_gr        <= '0;
         audio_l_o      <= '0;
         audio_r_o      <= '0;
         sample_valid_o <= 1'b0;
         overrun_o      <= 1'b0;
      end else begin
         sample_valid_o <= state == SAT;
         // A dropped strobe outranks a simultaneous clear.
         overrun_o      <= drop | (overrun_o & ~overrun_clr_i);
         if (accept) begin
            snap_s  <= samples_i;
            snap_gl <= gain_l_i;
            snap_gr <= gain_r_i;
            acc_l   <= '0;
            acc_r   <= '0;
            idx     <= '0;
         end
         if (state == MAC) begin
            acc_l <= idx[0] ? acc_l : acc_l + ACC_W'(prod);
            acc_r <= idx[0] ? acc_r + ACC_W'(prod) : acc_r;
            idx   <= idx + 1'b1;
         end
         if (state == SAT) begin
            audio_l_o <= sat_l;
            audio_r_o <= sat_r;
         end
      end
   end
   audio_mixer_sat #(.ACC_W(ACC_W), .GAIN_WIDTH(GAIN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_sat_l (
      .acc (acc_l),
      .sat (sat_l)
   );
   audio_mixer_sat #(.ACC_W(ACC_W), .GAIN_WIDTH(GAIN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_sat_r (
      .acc (acc_r),
      .sat (sat_r)
   );
`ifdef AUDIO_MIXER_PEAK_EN
   // A clear landing on the SAT cycle restarts tracking from the new sample.
   always_ff @(posedge clk_logic or negedge device_reset_n) begin
      if (!device_reset_n) begin
         peak_l_o <= '0;
         peak_r_o <= '0;
      end else if (state == SAT) begin
         peak_l_o <= (peak_clr_i || sat_l > peak_l_o) ? sat_l : peak_l_o;
         peak_r_o <= (peak_clr_i || sat_r > peak_r_o) ? sat_r : peak_r_o;
      end else if (peak_clr_i) begin
         peak_l_o <= '0;
         peak_r_o <= '0;
      end
   end
`endif
endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: scoreboard bench for audio_mixer (4 ch, 16-bit in, 8-bit gain, 16-bit out).
module tb_audio_mixer;
   import audio_mixer_pkg::*;
   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      int          cyc;
   } exp_t;
   localparam logic [7:0] U = 8'(unity_gain(8));
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        strobe = 1'b0;
   logic [63:0] samples = '0;
   logic [31:0] gl = '0, gr = '0;
   logic        oclr = 1'b0;
   logic [15:0] audio_l, audio_r;
   logic        valid, busy, overrun;
`ifdef AUDIO_MIXER_PEAK_EN
   logic        pclr = 1'b0;
   logic [15:0] peak_l, peak_r;
`endif
   exp_t q[$];
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   audio_mixer #(.NUM_CHANNELS(4), .IN_WIDTH(16), .GAIN_WIDTH(8), .OUT_WIDTH(16)) dut (
      .clk_logic       (clk),
      .device_reset_n  (rst_n),
      .sample_strobe_i (strobe),
      .samples_i       (samples),
      .gain_l_i        (gl),
      .gain_r_i        (gr),
      .overrun_clr_i   (oclr),
      .audio_l_o       (audio_l),
      .audio_r_o       (audio_r),
      .sample_valid_o  (valid),
      .busy_o          (busy),
      .overrun_o       (overrun)
`ifdef AUDIO_MIXER_PEAK_EN
      ,
      .peak_clr_i      (pclr),
      .peak_l_o        (peak_l),
      .peak_r_o        (peak_r)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every valid pulse must match the oldest expected mix, on the expected cycle.
   always @(negedge clk) begin
      if (valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid got 1 expected 0 at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("valid_cycle", cyc, e.cyc);
            chk("audio_l", {16'h0, audio_l}, {16'h0, e.l});
            chk("audio_r", {16'h0, audio_r}, {16'h0, e.r});
         end
      end
   end

   // Drives a one-cycle strobe; when push is set, the mix is expected 10 negedges later
   // (one edge to sample the strobe, then 2*4 MAC + 1 SAT edges).
   task automatic fire(input logic [63:0] s, input logic [31:0] l, input logic [31:0] r,
                       input logic push, input logic [15:0] el, input logic [15:0] er);
      exp_t e;
      @(negedge clk);
      samples = s;
      gl      = l;
      gr      = r;
      strobe  = 1'b1;
      if (push) begin
         e.l   = el;
         e.r   = er;
         e.cyc = cyc + 10;
         q.push_back(e);
      end
      @(negedge clk);
      strobe = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || q.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL wait_idle_timeout got busy=%0d pending=%0d expected 0 0", busy, q.size());
      end
      @(negedge clk);
   endtask

   task automatic pulse_oclr();
      @(negedge clk);
      oclr = 1'b1;
      @(negedge clk);
      oclr = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_audio_l", {16'h0, audio_l}, 32'h0);
      chk("rst_audio_r", {16'h0, audio_r}, 32'h0);
      chk("rst_valid", {31'h0, valid}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_overrun", {31'h0, overrun}, 32'h0);
      rst_n = 1'b1;

      // Unity left, half right on ch0.
      fire({48'h0, 16'h4000}, {24'h0, U}, {24'h0, 8'd64}, 1'b1, 16'h4000, 16'h2000);
      chk("busy_in_mac", {31'h0, busy}, 32'h1);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("hold_l", {16'h0, audio_l}, 32'h4000);
      chk("hold_r", {16'h0, audio_r}, 32'h2000);

      // Two channels accumulate: L = 0x1000+0x1000, R = 0x0800+0x2000.
      fire({32'h0, 16'h2000, 16'h1000}, {16'h0, 8'd64, U}, {16'h0, U, 8'd64}, 1'b1, 16'h2000, 16'h2800);
      wait_idle();

      // Saturation.
      fire({4{16'hFFFF}}, {4{8'hFF}}, {4{8'hFF}}, 1'b1, 16'hFFFF, 16'hFFFF);
      wait_idle();

      // Overrun: second strobe 3 cycles later with a clear in the same cycle; set wins.
      fire({32'h0, 16'h1000, 16'h0}, {16'h0, U, 8'h0}, {16'h0, U, 8'h0}, 1'b1, 16'h1000, 16'h1000);
      @(negedge clk);
      @(negedge clk);
      samples = {4{16'h7777}};
      strobe  = 1'b1;
      oclr    = 1'b1;
      @(negedge clk);
      strobe  = 1'b0;
      oclr    = 1'b0;
      chk("overrun_set_wins", {31'h0, overrun}, 32'h1);
      wait_idle();
      chk("overrun_sticky", {31'h0, overrun}, 32'h1);
      pulse_oclr();
      chk("overrun_cleared", {31'h0, overrun}, 32'h0);

      // Strobe landing on the SAT cycle is dropped and flags overrun.
      fire({16'h0, 16'h0800, 32'h0}, {8'h0, U, 16'h0}, {8'h0, U, 16'h0}, 1'b1, 16'h0800, 16'h0800);
      repeat (8) @(negedge clk);
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      chk("sat_strobe_not_busy", {31'h0, busy}, 32'h0);
      chk("sat_strobe_overrun", {31'h0, overrun}, 32'h1);
      wait_idle();
      pulse_oclr();

      // Reset mid-MAC abandons the sample.
      fire({4{16'h1234}}, {4{U}}, {4{U}}, 1'b0, 16'h0, 16'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_audio_l", {16'h0, audio_l}, 32'h0);
      chk("midrst_audio_r", {16'h0, audio_r}, 32'h0);
      chk("midrst_busy", {31'h0, busy}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);

      // First strobe after reset; truncation of the fraction bits: 0x100*255>>7, 0x100*1>>7.
      fire({16'h0, 16'h0100, 32'h0}, {8'h0, 8'hFF, 16'h0}, {8'h0, 8'h01, 16'h0}, 1'b1, 16'h01FE, 16'h0002);
      wait_idle();

      // Snapshot: inputs change during MAC but the mix uses strobe-time values.
      fire({16'h8000, 48'h0}, {U, 24'h0}, {8'd32, 24'h0}, 1'b1, 16'h8000, 16'h2000);
      samples = {4{16'hFFFF}};
      gl      = {4{8'hFF}};
      gr      = {4{8'hFF}};
      wait_idle();

`ifdef AUDIO_MIXER_PEAK_EN
      @(negedge clk);
      pclr = 1'b1;
      @(negedge clk);
      pclr = 1'b0;
      fire({48'h0, 16'h1000}, {24'h0, U}, 32'h0, 1'b1, 16'h1000, 16'h0);
      wait_idle();
      fire({48'h0, 16'h3000}, {24'h0, U}, 32'h0, 1'b1, 16'h3000, 16'h0);
      wait_idle();
      fire({48'h0, 16'h2000}, {24'h0, U}, 32'h0, 1'b1, 16'h2000, 16'h0);
      wait_idle();
      chk("peak_l", {16'h0, peak_l}, 32'h3000);
      chk("peak_r", {16'h0, peak_r}, 32'h0);
      @(negedge clk);
      pclr = 1'b1;
      @(negedge clk);
      pclr = 1'b0;
      chk("peak_l_clr", {16'h0, peak_l}, 32'h0);
`endif

      repeat (5) @(negedge clk);
      chk("queue_drained", q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
